// File: rtl/stopwatch_pkg.sv
// Shared types and elaboration-time helpers for the stopwatch control slice.
// The state encoding is also the led code driven to the board.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
    endfunction

    // Legal only when the tick divides the clock exactly and leaves at least two cycles per tick.
    function automatic bit div_ok(input int unsigned clk_hz, input int unsigned tick_hz);
        return (tick_hz != 0) && (clk_hz % tick_hz == 0) && (clk_hz / tick_hz >= 2);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter, rising-edge pulse.
// A held button yields exactly one single-cycle pulse; En low freezes the debouncer and masks the pulse.
module btn_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic En,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned    CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= En & level & ~level_d;
            // The level flips on the DB_CYCLES-th consecutive differing sample.
            if (En) begin
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear sequencer: conditions start/stop/inc buttons and
// generates the registered count-enable tick and step/clear pulses for the digit counters.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       En,
    input  logic       start,
    input  logic       stop,
    input  logic       inc,
    output logic       cnt_en,
    output logic       inc_step,
    output logic       clr,
    output logic [1:0] led
);

    localparam int unsigned   DIV      = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned   DW       = cnt_width(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_div_check
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
    end

    logic p_start;
    logic p_stop;
    logic p_inc;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start (
        .clock(clock), .reset(reset), .En(En), .btn_raw(start), .pulse(p_start)
    );
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_stop (
        .clock(clock), .reset(reset), .En(En), .btn_raw(stop), .pulse(p_stop)
    );
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_inc (
        .clock(clock), .reset(reset), .En(En), .btn_raw(inc), .pulse(p_inc)
    );

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] div;
    logic [DW-1:0] div_nx;
    logic          cnt_en_nx;
    logic          inc_step_nx;
    logic          clr_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            cnt_en   <= 1'b0;
            inc_step <= 1'b0;
            clr      <= 1'b1;
        end else begin
            state    <= state_nx;
            div      <= div_nx;
            cnt_en   <= cnt_en_nx;
            inc_step <= inc_step_nx;
            clr      <= clr_nx;
        end
    end

    // Priority stop > start > inc; in IDLE a stop pulse is a no-op that still consumes the cycle.
    always_comb begin
        state_nx    = state;
        div_nx      = div;
        cnt_en_nx   = 1'b0;
        inc_step_nx = 1'b0;
        clr_nx      = 1'b0;
        if (En) begin
            unique case (state)
                IDLE: begin
                    div_nx = '0;
                    if (!p_stop) begin
                        if (p_start) begin
                            state_nx = RUN;
                        end else if (p_inc) begin
                            inc_step_nx = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (div == DIV_LAST) begin
                        div_nx    = '0;
                        cnt_en_nx = 1'b1;
                    end else begin
                        div_nx = div + DW'(1);
                    end
                    if (p_stop) begin
                        state_nx = PAUSE;
                    end
                end
                PAUSE: begin
                    if (p_stop) begin
                        state_nx = IDLE;
                        clr_nx   = 1'b1;
                    end else if (p_start) begin
                        state_nx = RUN;
                    end else if (p_inc) begin
                        inc_step_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign led = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and DB_CYCLES=4.
// Button press -> pulse takes 7 edges; the state change is visible one edge later.
module tb_stopwatch_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       start;
    logic       stop;
    logic       inc;
    logic       cnt_en;
    logic       inc_step;
    logic       clr;
    logic [1:0] led;

    int tests = 0;
    int fails = 0;

    stopwatch_ctrl #(
        .CLK_HZ(100),
        .TICK_HZ(10),
        .DB_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .En(en),
        .start(start),
        .stop(stop),
        .inc(inc),
        .cnt_en(cnt_en),
        .inc_step(inc_step),
        .clr(clr),
        .led(led)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        bit         en;
        bit         start;
        bit         stop;
        bit         inc;
        int         cycles;
        logic [1:0] led;
        int         n_cnt;
        int         n_inc;
        int         n_clr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input bit e, input bit s, input bit p, input bit i,
                                input int cyc, input logic [1:0] l, input int c, input int ic, input int cl);
        vec_t v;
        v.name = nm; v.en = e; v.start = s; v.stop = p; v.inc = i;
        v.cycles = cyc; v.led = l; v.n_cnt = c; v.n_inc = ic; v.n_clr = cl;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_led(input logic [1:0] want, input int max, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (led != want && n < max);
    endtask

    task automatic wait_cnt_en(input int max, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (cnt_en !== 1'b1 && n < max);
    endtask

    initial begin
        int n;
        int c_cnt;
        int c_inc;
        int c_clr;

        // Vector table: inputs held for 'cycles' edges, pulses counted over that window.
        //   name   en s  p  i  cyc  led    cnt inc clr
        add("T1",  1, 0, 0, 0,  7, 2'b01, 0, 0, 0);   // release start, div -> 7
        add("T2",  1, 0, 1, 0, 10, 2'b10, 1, 0, 0);   // wrap on 3rd edge, PAUSE with div=5
        add("T3",  1, 0, 0, 0, 20, 2'b10, 0, 0, 0);   // paused: no ticks
        add("T4",  1, 0, 0, 1, 10, 2'b10, 0, 1, 0);   // inc in PAUSE
        add("T5",  1, 0, 0, 0,  8, 2'b10, 0, 0, 0);
        add("T6",  1, 1, 0, 0,  8, 2'b01, 0, 0, 0);   // resume
        add("T7",  1, 0, 0, 0,  4, 2'b01, 0, 0, 0);   // div 6..9
        add("T8",  1, 0, 0, 0,  1, 2'b01, 1, 0, 0);   // tick exactly 5 after resume
        add("T9",  1, 0, 0, 0, 10, 2'b01, 1, 0, 0);
        add("T10", 1, 0, 1, 0,  8, 2'b10, 0, 0, 0);   // pause at div=8
        add("T11", 1, 0, 0, 0,  8, 2'b10, 0, 0, 0);
        add("T12", 1, 0, 1, 0,  8, 2'b00, 0, 0, 1);   // stop in PAUSE -> IDLE + clr
        add("T13", 1, 0, 0, 0,  8, 2'b00, 0, 0, 0);   // clr lasted one cycle
        add("T14", 1, 1, 0, 0,  8, 2'b01, 0, 0, 0);
        add("T15", 1, 0, 0, 0,  9, 2'b01, 0, 0, 0);   // divider was cleared in IDLE
        add("T16", 1, 0, 0, 0,  1, 2'b01, 1, 0, 0);
        add("T17", 1, 0, 0, 0,  3, 2'b01, 0, 0, 0);   // div=3
        add("T18", 0, 1, 0, 1, 30, 2'b01, 0, 0, 0);   // En low: frozen
        add("T19", 1, 0, 0, 0,  6, 2'b01, 0, 0, 0);   // div 4..9
        add("T20", 1, 0, 0, 0,  1, 2'b01, 1, 0, 0);
        add("T21", 1, 0, 1, 0,  8, 2'b10, 0, 0, 0);
        add("T22", 1, 0, 0, 0,  8, 2'b10, 0, 0, 0);
        add("T23", 1, 1, 1, 0,  8, 2'b00, 0, 0, 1);   // start+stop in PAUSE
        add("T24", 1, 0, 0, 0,  8, 2'b00, 0, 0, 0);
        add("T25", 1, 1, 1, 0,  8, 2'b00, 0, 0, 0);   // start+stop in IDLE
        add("T26", 1, 0, 0, 0,  8, 2'b00, 0, 0, 0);
        add("T27", 1, 0, 0, 1, 16, 2'b00, 0, 1, 0);   // held inc: one step
        add("T28", 1, 0, 0, 0,  8, 2'b00, 0, 0, 0);
        add("T29", 0, 0, 0, 1, 10, 2'b00, 0, 0, 0);   // press during En low
        add("T30", 1, 0, 0, 0, 10, 2'b00, 0, 0, 0);   // is discarded
        add("B1",  1, 1, 0, 0,  2, 2'b00, 0, 0, 0);   // bouncing start
        add("B2",  1, 0, 0, 0,  2, 2'b00, 0, 0, 0);
        add("B3",  1, 1, 0, 0,  2, 2'b00, 0, 0, 0);
        add("B4",  1, 0, 0, 0,  2, 2'b00, 0, 0, 0);
        add("B5",  1, 1, 0, 0,  2, 2'b00, 0, 0, 0);
        add("B6",  1, 0, 0, 0,  2, 2'b00, 0, 0, 0);
        add("B7",  1, 1, 0, 0,  7, 2'b00, 0, 0, 0);   // settled high, not yet accepted
        add("B8",  1, 1, 0, 0,  1, 2'b01, 0, 0, 0);

        // Reset state
        reset = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; inc = 1'b0;
        repeat (3) cycle();
        chk("rst.led", int'(led), 0);
        chk("rst.clr", int'(clr), 1);
        chk("rst.cnt_en", int'(cnt_en), 0);
        chk("rst.inc_step", int'(inc_step), 0);
        reset = 1'b0;
        cycle();
        chk("rst.clr_drop", int'(clr), 0);
        chk("rst.led_after", int'(led), 0);

        // Held start: RUN 8 edges after press, then ticks every 10 cycles
        start = 1'b1;
        wait_led(2'b01, 20, n);
        chk("run.latency", n, 8);
        wait_cnt_en(20, n);
        chk("run.tick1", n, 10);
        wait_cnt_en(20, n);
        chk("run.tick2", n, 10);
        wait_cnt_en(20, n);
        chk("run.tick3", n, 10);
        chk("run.clr", int'(clr), 0);

        foreach (vecs[k]) begin
            en = vecs[k].en; start = vecs[k].start; stop = vecs[k].stop; inc = vecs[k].inc;
            c_cnt = 0; c_inc = 0; c_clr = 0;
            repeat (vecs[k].cycles) begin
                cycle();
                c_cnt += int'(cnt_en);
                c_inc += int'(inc_step);
                c_clr += int'(clr);
            end
            chk({vecs[k].name, ".led"}, int'(led), int'(vecs[k].led));
            chk({vecs[k].name, ".cnt_en"}, c_cnt, vecs[k].n_cnt);
            chk({vecs[k].name, ".inc_step"}, c_inc, vecs[k].n_inc);
            chk({vecs[k].name, ".clr"}, c_clr, vecs[k].n_clr);
        end

        // Reset mid-RUN on the edge that would have produced a tick
        c_cnt = 0;
        repeat (9) begin
            cycle();
            c_cnt += int'(cnt_en);
        end
        chk("mid.pre_ticks", c_cnt, 0);
        reset = 1'b1; start = 1'b0;
        cycle();
        chk("mid.cnt_en", int'(cnt_en), 0);
        chk("mid.inc_step", int'(inc_step), 0);
        chk("mid.clr", int'(clr), 1);
        chk("mid.led", int'(led), 0);
        reset = 1'b0;
        cycle();
        chk("mid.clr_drop", int'(clr), 0);
        c_cnt = 0;
        repeat (20) begin
            cycle();
            c_cnt += int'(cnt_en);
        end
        chk("mid.idle_ticks", c_cnt, 0);
        chk("mid.idle_led", int'(led), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
